// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal direction predictor with branch target buffer.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor #(
  parameter int          ENTRIES  = 64,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        lk_valid_i,
  input  logic [31:0] lk_pc_i,
  output logic        pred_valid_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
`ifdef BP_STATS_EN
  ,
  input  logic        upd_pred_taken_i,
  output logic [31:0] stat_lookups_o,
  output logic [31:0] stat_updates_o,
  output logic [31:0] stat_mispred_o
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [1:0]         cnt     [ENTRIES];
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [31:0]        tgt_mem [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit, lk_taken;
  logic             unused_pc_bits;

  assign lk_idx  = lk_pc_i[IDX_W+1:2];
  assign lk_tag  = lk_pc_i[31:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[31:IDX_W+2];
  assign unused_pc_bits = ^{lk_pc_i[1:0], upd_pc_i[1:0]};

  // The valid bit gates the compare so uninitialised tag/target never leak out.
  assign lk_hit   = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign upd_hit  = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign lk_taken = lk_hit && cnt[lk_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_o  <= 1'b0;
      pred_taken_o  <= 1'b0;
      pred_target_o <= 32'd0;
    end else begin
      pred_valid_o  <= lk_valid_i;
      pred_taken_o  <= lk_valid_i && lk_taken;
      pred_target_o <= (lk_valid_i && lk_taken) ? tgt_mem[lk_idx] : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        cnt[i]   <= CNT_INIT;
      end
    end else if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
      end
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        if (upd_taken_i && cnt[upd_idx] != 2'b11) begin
          cnt[upd_idx] <= cnt[upd_idx] + 2'b01;
        end else if (!upd_taken_i && cnt[upd_idx] != 2'b00) begin
          cnt[upd_idx] <= cnt[upd_idx] - 2'b01;
        end
      end else if (upd_taken_i) begin
        valid[upd_idx] <= 1'b1;
        cnt[upd_idx]   <= 2'b10;
      end
    end
  end

  // Taken updates write tag/target both for a hit (tag unchanged) and an allocation.
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i && upd_valid_i && upd_taken_i) begin
      tag_mem[upd_idx] <= upd_tag;
      tgt_mem[upd_idx] <= upd_target_i;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups_o <= 32'd0;
      stat_updates_o <= 32'd0;
      stat_mispred_o <= 32'd0;
    end else begin
      if (lk_valid_i && stat_lookups_o != 32'hFFFF_FFFF)
        stat_lookups_o <= stat_lookups_o + 32'd1;
      if (upd_valid_i && stat_updates_o != 32'hFFFF_FFFF)
        stat_updates_o <= stat_updates_o + 32'd1;
      if (upd_valid_i && (upd_pred_taken_i != upd_taken_i) && stat_mispred_o != 32'hFFFF_FFFF)
        stat_mispred_o <= stat_mispred_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed vector bench for branch_predictor.
// Statistics checks are compiled in when BP_STATS_EN is defined.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
`ifdef BP_STATS_EN
  logic        upd_pred_taken;
  logic [31:0] stat_lookups, stat_updates, stat_mispred;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush),
    .lk_valid_i    (lk_valid),
    .lk_pc_i       (lk_pc),
    .pred_valid_o  (pred_valid),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .upd_valid_i   (upd_valid),
    .upd_pc_i      (upd_pc),
    .upd_taken_i   (upd_taken),
    .upd_target_i  (upd_target)
`ifdef BP_STATS_EN
    ,
    .upd_pred_taken_i (upd_pred_taken),
    .stat_lookups_o   (stat_lookups),
    .stat_updates_o   (stat_updates),
    .stat_mispred_o   (stat_mispred)
`endif
  );

  typedef struct {
    logic        flush;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        exp_valid;
    logic        exp_taken;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic f, input logic lv, input logic [31:0] lpc,
                     input logic uv, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utgt, input logic ev, input logic et,
                     input logic [31:0] etgt);
    vec_t v;
    v.flush = f; v.lk_valid = lv; v.lk_pc = lpc;
    v.upd_valid = uv; v.upd_pc = upc; v.upd_taken = ut; v.upd_target = utgt;
    v.exp_valid = ev; v.exp_taken = et; v.exp_target = etgt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else
      passed++;
  endtask

  task automatic drive(input vec_t v);
    flush = v.flush; lk_valid = v.lk_valid; lk_pc = v.lk_pc;
    upd_valid = v.upd_valid; upd_pc = v.upd_pc; upd_taken = v.upd_taken;
    upd_target = v.upd_target;
  endtask

  task automatic idle();
    flush = 1'b0; lk_valid = 1'b0; lk_pc = 32'd0;
    upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0; upd_target = 32'd0;
`ifdef BP_STATS_EN
    upd_pred_taken = 1'b0;
`endif
  endtask

  task automatic check_pred(input string tag, input logic ev, input logic et,
                            input logic [31:0] etgt);
    chk({tag, ".valid"},  {31'd0, pred_valid}, {31'd0, ev});
    chk({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, et});
    chk({tag, ".target"}, pred_target, etgt);
  endtask

  initial begin
    // f lv  lk_pc        uv  upd_pc        ut  target     ev et  exp_target
    add(0, 1, 32'h100, 0, 32'h0,   0, 32'h0,  1, 0, 32'h0);
    add(0, 0, 32'h0,   1, 32'h100, 1, 32'h80, 0, 0, 32'h0);
    add(0, 1, 32'h100, 0, 32'h0,   0, 32'h0,  1, 1, 32'h80);
    add(0, 1, 32'h100, 1, 32'h100, 0, 32'h0,  1, 1, 32'h80);
    add(0, 1, 32'h100, 1, 32'h100, 0, 32'h0,  1, 0, 32'h0);
    add(0, 1, 32'h100, 1, 32'h100, 0, 32'h0,  1, 0, 32'h0);
    add(0, 1, 32'h100, 1, 32'h100, 0, 32'h0,  1, 0, 32'h0);
    add(0, 1, 32'h100, 0, 32'h0,   0, 32'h0,  1, 0, 32'h0);
    add(0, 0, 32'h0,   1, 32'h100, 1, 32'h84, 0, 0, 32'h0);
    add(0, 0, 32'h0,   1, 32'h100, 1, 32'h84, 0, 0, 32'h0);
    add(0, 1, 32'h100, 0, 32'h0,   0, 32'h0,  1, 1, 32'h84);
    add(0, 0, 32'h0,   1, 32'h200, 1, 32'h40, 0, 0, 32'h0);
    add(0, 1, 32'h100, 0, 32'h0,   0, 32'h0,  1, 0, 32'h0);
    add(0, 1, 32'h200, 0, 32'h0,   0, 32'h0,  1, 1, 32'h40);
    add(0, 1, 32'h104, 0, 32'h0,   0, 32'h0,  1, 0, 32'h0);
    add(0, 0, 32'h0,   1, 32'h208, 0, 32'h0,  0, 0, 32'h0);
    add(0, 1, 32'h208, 0, 32'h0,   0, 32'h0,  1, 0, 32'h0);
    add(0, 0, 32'h0,   1, 32'h200, 1, 32'h40, 0, 0, 32'h0);
    add(0, 0, 32'h0,   1, 32'h200, 1, 32'h40, 0, 0, 32'h0);
    add(0, 0, 32'h0,   1, 32'h200, 0, 32'h0,  0, 0, 32'h0);
    add(0, 1, 32'h200, 1, 32'h200, 0, 32'h0,  1, 1, 32'h40);
    add(0, 1, 32'h200, 0, 32'h0,   0, 32'h0,  1, 0, 32'h0);
    add(0, 1, 32'h300, 1, 32'h300, 1, 32'h30, 1, 0, 32'h0);
    add(0, 1, 32'h300, 0, 32'h0,   0, 32'h0,  1, 1, 32'h30);
    add(0, 0, 32'h0,   1, 32'h104, 1, 32'h10, 0, 0, 32'h0);
    add(0, 1, 32'h104, 0, 32'h0,   0, 32'h0,  1, 1, 32'h10);
    add(1, 1, 32'h300, 1, 32'h400, 1, 32'h44, 1, 1, 32'h30);
    add(0, 1, 32'h300, 0, 32'h0,   0, 32'h0,  1, 0, 32'h0);
    add(0, 1, 32'h104, 0, 32'h0,   0, 32'h0,  1, 0, 32'h0);
    add(0, 1, 32'h400, 0, 32'h0,   0, 32'h0,  1, 0, 32'h0);
    add(0, 0, 32'h0,   0, 32'h400, 1, 32'h44, 0, 0, 32'h0);
    add(0, 1, 32'h400, 0, 32'h0,   0, 32'h0,  1, 0, 32'h0);

    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check_pred("reset", 1'b0, 1'b0, 32'h0);
`ifdef BP_STATS_EN
    chk("reset.stat_lookups", stat_lookups, 32'd0);
    chk("reset.stat_updates", stat_updates, 32'd0);
    chk("reset.stat_mispred", stat_mispred, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_pred($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_taken,
                 vecs[i].exp_target);
    end

    // Mid-operation reset: outputs clear immediately and the pending update is lost.
    @(negedge clk);
    idle();
    upd_valid = 1'b1; upd_pc = 32'h500; upd_taken = 1'b1; upd_target = 32'h50;
    @(negedge clk);
    idle();
    lk_valid = 1'b1; lk_pc = 32'h500;
    @(posedge clk);
    #1;
    check_pred("pre_rst", 1'b1, 1'b1, 32'h50);
    @(negedge clk);
    idle();
    upd_valid = 1'b1; upd_pc = 32'h600; upd_taken = 1'b1; upd_target = 32'h60;
    #2;
    rst_n = 1'b0;
    #1;
    check_pred("async_rst", 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    lk_valid = 1'b1; lk_pc = 32'h500;
    @(posedge clk);
    #1;
    check_pred("post_rst_500", 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    lk_pc = 32'h600;
    @(posedge clk);
    #1;
    check_pred("post_rst_600", 1'b1, 1'b0, 32'h0);

`ifdef BP_STATS_EN
    // Statistics: 3 lookups, 2 updates, 1 mispredict, then a flush that must not clear them.
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    lk_valid = 1'b1; lk_pc = 32'h100;
    @(negedge clk);
    lk_pc = 32'h104;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_pred_taken = 1'b0;
    @(negedge clk);
    lk_pc = 32'h100;
    upd_pred_taken = 1'b1;
    @(negedge clk);
    idle();
    flush = 1'b1;
    @(negedge clk);
    idle();
    chk("stat_lookups", stat_lookups, 32'd3);
    chk("stat_updates", stat_updates, 32'd2);
    chk("stat_mispred", stat_mispred, 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
